// File: rtl/multiplier_seq_radix4_if.sv
// Operand/product handshake bundle for the radix-4 sequential multiplier.
// Master drives operands and accepts products; slave is the multiplier.
interface multiplier_seq_radix4_if #(
  parameter int WIDTH = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  modport master (
    output in_valid, m, q, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, m, q, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/multiplier_seq_radix4.sv
// Sequential unsigned multiplier: one m x 2-bit row reused WIDTH/2 times,
// shift-accumulating into a 2*WIDTH product with valid/ready on both sides.
module multiplier_seq_radix4 #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  multiplier_seq_radix4_if.slave bus
);

  localparam int SL = WIDTH / 2;
  localparam int CW = $clog2(SL + 1);
  localparam logic [CW-1:0] LAST = CW'(SL - 1);

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("multiplier_seq_radix4: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   q_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] prod_q;
  logic               ov_q;
  logic               busy_q;

  logic [1:0]         slice;
  logic [WIDTH+1:0]   pp;
  logic [WIDTH+1:0]   s;
  logic [2*WIDTH+1:0] cat;
  logic [2*WIDTH-1:0] acc_d;
  logic               last;

  // One row: m times the current 2-bit slice, added to the upper half,
  // then the whole accumulator shifts right by one slice.
  always_comb begin
    slice = 2'(q_q >> {cnt_q, 1'b0});
    pp    = (WIDTH+2)'(m_q) * (WIDTH+2)'(slice);
    s     = (WIDTH+2)'(acc_q[2*WIDTH-1:WIDTH]) + pp;
    cat   = {s, acc_q[WIDTH-1:0]};
    acc_d = (2*WIDTH)'(cat >> 2);
    last  = (cnt_q == LAST);
  end

  // Control FSM with registered datapath and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            m_q     <= bus.m;
            q_q     <= bus.q;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            prod_q  <= acc_d;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ov_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.product   = prod_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_multiplier_seq_radix4.sv
// Bench for multiplier_seq_radix4: WIDTH=4 and WIDTH=8 instances driven by
// directed vectors, with queue-based monitors checking product and latency.
module tb_multiplier_seq_radix4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  multiplier_seq_radix4_if #(.WIDTH(4)) b4 ();
  multiplier_seq_radix4_if #(.WIDTH(8)) b8 ();

  multiplier_seq_radix4 #(.WIDTH(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  multiplier_seq_radix4 #(.WIDTH(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8)
  );

  typedef struct {
    logic [15:0] p;
    int          c;
  } exp_t;

  exp_t exp4[$];
  exp_t exp8[$];
  bit   pv4 = 1'b0;
  bit   pv8 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else
      n_pass++;
  endtask

  // Monitor for the WIDTH=4 instance: product every valid cycle,
  // latency on the first valid cycle, pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv4 = 1'b0;
    end else begin
      if (b4.out_valid) begin
        if (exp4.size() == 0) begin
          n_tot++;
          $display("FAIL unexp4: product %0h with no pending op", b4.product);
        end else begin
          chk("prod4", 32'(b4.product), 32'(exp4[0].p));
          if (!pv4) chk("lat4", cyc, exp4[0].c);
          if (b4.out_ready) void'(exp4.pop_front());
        end
      end
      pv4 = b4.out_valid;
    end
  end

  // Same monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv8 = 1'b0;
    end else begin
      if (b8.out_valid) begin
        if (exp8.size() == 0) begin
          n_tot++;
          $display("FAIL unexp8: product %0h with no pending op", b8.product);
        end else begin
          chk("prod8", 32'(b8.product), 32'(exp8[0].p));
          if (!pv8) chk("lat8", cyc, exp8[0].c);
          if (b8.out_ready) void'(exp8.pop_front());
        end
      end
      pv8 = b8.out_valid;
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic issue4(input logic [3:0] m, input logic [3:0] q,
                        input bit hold, input logic [15:0] p);
    int i = 0;
    b4.m = m;
    b4.q = q;
    b4.in_valid = 1'b1;
    while (!b4.in_ready && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    if (!b4.in_ready) begin
      chk("acc4_timeout", 32'(b4.in_ready), 32'd1);
      b4.in_valid = 1'b0;
      return;
    end
    exp4.push_back('{p: p, c: cyc + 3});
    @(posedge clk); #1;
    b4.in_valid = hold;
  endtask

  task automatic issue8(input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] p);
    int i = 0;
    b8.m = m;
    b8.q = q;
    b8.in_valid = 1'b1;
    while (!b8.in_ready && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    if (!b8.in_ready) begin
      chk("acc8_timeout", 32'(b8.in_ready), 32'd1);
      b8.in_valid = 1'b0;
      return;
    end
    exp8.push_back('{p: p, c: cyc + 5});
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((exp4.size() != 0 || exp8.size() != 0) && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain", exp4.size() + exp8.size(), 0);
  endtask

  initial begin
    b4.in_valid = 1'b0; b4.m = '0; b4.q = '0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.m = '0; b8.q = '0; b8.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready4", 32'(b4.in_ready), 1);
    chk("rst_valid4", 32'(b4.out_valid), 0);
    chk("rst_prod4", 32'(b4.product), 0);
    chk("rst_busy4", 32'(b4.busy), 0);
    chk("rst_ready8", 32'(b8.in_ready), 1);
    chk("rst_prod8", 32'(b8.product), 0);

    @(posedge clk); #1;
    issue4(4'd13, 4'd11, 1'b0, 16'h008F);
    @(posedge clk); #1;
    chk("busy_calc", 32'(b4.busy), 1);
    @(posedge clk); #1;
    chk("v_at_e2", 32'(b4.out_valid), 1);
    chk("p_at_e2", 32'(b4.product), 32'h8F);
    @(posedge clk); #1;
    chk("v_after", 32'(b4.out_valid), 0);
    chk("rdy_after", 32'(b4.in_ready), 1);

    issue4(4'd15, 4'd15, 1'b1, 16'h00E1);
    issue4(4'd0, 4'd9, 1'b1, 16'h0000);
    issue4(4'd1, 4'd15, 1'b0, 16'h000F);
    drain();

    b4.out_ready = 1'b0;
    issue4(4'd7, 4'd9, 1'b0, 16'h003F);
    for (int i = 0; i < 20 && !b4.out_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_valid", 32'(b4.out_valid), 1);
    for (int k = 0; k < 5; k++) begin
      b4.in_valid = 1'b1;
      b4.m = 4'd2;
      b4.q = 4'd2;
      chk("bp_ready", 32'(b4.in_ready), 0);
      chk("bp_hold", 32'(b4.product), 32'h3F);
      @(posedge clk); #1;
    end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 32'(b4.in_ready), 1);
    issue4(4'd2, 4'd2, 1'b0, 16'h0004);
    drain();

    issue8(8'd17, 8'd19, 16'd323);
    drain();
    issue8(8'd200, 8'd150, 16'd30000);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid8", 32'(b8.out_valid), 0);
    chk("arst_prod8", 32'(b8.product), 0);
    chk("arst_busy8", 32'(b8.busy), 0);
    chk("arst_ready8", 32'(b8.in_ready), 1);
    chk("arst_prod4", 32'(b4.product), 0);
    exp8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_stale8", 32'(b8.out_valid), 0);
    issue8(8'd255, 8'd255, 16'hFE01);
    issue8(8'd200, 8'd150, 16'd30000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
